// File: rtl/asansor_pkg.sv
// Shared types and constants for the elevator cab controller.
// Floor count/width, FSM state encoding and travel direction.
package asansor_pkg;

    localparam int KAT_SAYISI = 4;
    localparam int KAT_W      = 2;

    typedef enum logic [1:0] {
        BEKLE   = 2'd0,
        HAREKET = 2'd1,
        KAPI    = 2'd2
    } kabin_durum_t;

    typedef enum logic {
        ASAGI  = 1'b0,
        YUKARI = 1'b1
    } yon_t;

endpackage

// File: rtl/asansor_kabin_zamanlayici.sv
// Loadable down-counter used for floor travel and door timing.
// Ports: clk, rst, yukle (load), yukle_deger (load value), sifir (count == 0).
module asansor_zamanlayici #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         yukle,
    input  logic [W-1:0] yukle_deger,
    output logic         sifir
);

    logic [W-1:0] sayac_q;
    logic [W-1:0] sayac_d;

    // Load wins over decrement; the count parks at zero once reached.
    always_comb begin
        sayac_d = sayac_q;
        if (yukle) begin
            sayac_d = yukle_deger;
        end else if (sayac_q != '0) begin
            sayac_d = sayac_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sayac_q <= '0;
        end else begin
            sayac_q <= sayac_d;
        end
    end

    assign sifir = (sayac_q == '0);

endmodule

// File: rtl/asansor_kabin.sv
// Elevator cab controller: accepts a target floor, travels one floor per
// KAT_SURESI cycles, then holds the door open for KAPI_SURESI cycles.
// Ports: clk, rst, hedef_kat/istek_gecerli/istek_hazir (request handshake),
// bulundugu_kat (current floor), yon_yukari/yon_asagi, kapi_acik, mesgul.
module asansor_kabin #(
    parameter int KAT_W       = 2,
    parameter int KAT_SURESI  = 4,
    parameter int KAPI_SURESI = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KAT_W-1:0] hedef_kat,
    input  logic             istek_gecerli,
    output logic             istek_hazir,
    output logic [KAT_W-1:0] bulundugu_kat,
    output logic             yon_yukari,
    output logic             yon_asagi,
    output logic             kapi_acik,
    output logic             mesgul
);

    import asansor_pkg::*;

    localparam int MAKS_SURE =
        (KAT_SURESI > KAPI_SURESI) ? KAT_SURESI : KAPI_SURESI;
    localparam int ZW = (MAKS_SURE > 1) ? $clog2(MAKS_SURE) : 1;

    localparam logic [ZW-1:0] KAT_YUKLE  = ZW'(KAT_SURESI - 1);
    localparam logic [ZW-1:0] KAPI_YUKLE = ZW'(KAPI_SURESI - 1);

    kabin_durum_t     durum_q, durum_d;
    logic [KAT_W-1:0] kat_q, kat_d;
    logic [KAT_W-1:0] hedef_q, hedef_d;
    yon_t             yon_q, yon_d;

    logic          yukle;
    logic [ZW-1:0] yukle_deger;
    logic          sifir;

    asansor_zamanlayici #(
        .W (ZW)
    ) u_zamanlayici (
        .clk         (clk),
        .rst         (rst),
        .yukle       (yukle),
        .yukle_deger (yukle_deger),
        .sifir       (sifir)
    );

    always_comb begin
        durum_d     = durum_q;
        kat_d       = kat_q;
        hedef_d     = hedef_q;
        yon_d       = yon_q;
        yukle       = 1'b0;
        yukle_deger = '0;

        unique case (durum_q)
            BEKLE: begin
                if (istek_gecerli) begin
                    hedef_d = hedef_kat;
                    yukle   = 1'b1;
                    if (hedef_kat == kat_q) begin
                        durum_d     = KAPI;
                        yukle_deger = KAPI_YUKLE;
                    end else begin
                        durum_d     = HAREKET;
                        yukle_deger = KAT_YUKLE;
                        yon_d       = (hedef_kat > kat_q) ? YUKARI : ASAGI;
                    end
                end
            end
            HAREKET: begin
                if (sifir) begin
                    // Step toward the latched target; it is always a
                    // valid floor, so the step can never wrap.
                    if (yon_q == YUKARI) begin
                        kat_d = kat_q + KAT_W'(1);
                    end else begin
                        kat_d = kat_q - KAT_W'(1);
                    end
                    yukle = 1'b1;
                    if (kat_d == hedef_q) begin
                        durum_d     = KAPI;
                        yukle_deger = KAPI_YUKLE;
                    end else begin
                        yukle_deger = KAT_YUKLE;
                    end
                end
            end
            KAPI: begin
                if (sifir) begin
                    durum_d = BEKLE;
                end
            end
            default: begin
                durum_d = BEKLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            durum_q <= BEKLE;
            kat_q   <= '0;
            hedef_q <= '0;
            yon_q   <= ASAGI;
        end else begin
            durum_q <= durum_d;
            kat_q   <= kat_d;
            hedef_q <= hedef_d;
            yon_q   <= yon_d;
        end
    end

    // Direction outputs are qualified by state, so they drop on the same
    // edge that enters KAPI and can never overlap the open door.
    assign istek_hazir   = (durum_q == BEKLE);
    assign mesgul        = ~istek_hazir;
    assign bulundugu_kat = kat_q;
    assign yon_yukari    = (durum_q == HAREKET) && (yon_q == YUKARI);
    assign yon_asagi     = (durum_q == HAREKET) && (yon_q == ASAGI);
    assign kapi_acik     = (durum_q == KAPI);

endmodule

// File: tb/tb_asansor_kabin.sv
// Directed self-checking bench for asansor_kabin (default parameters).
// Samples outputs 1 time unit after each rising edge.
module tb_asansor_kabin;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] hedef_kat;
    logic       istek_gecerli;
    logic       istek_hazir;
    logic [1:0] bulundugu_kat;
    logic       yon_yukari;
    logic       yon_asagi;
    logic       kapi_acik;
    logic       mesgul;

    int checks   = 0;
    int failures = 0;

    asansor_kabin #(
        .KAT_W       (2),
        .KAT_SURESI  (4),
        .KAPI_SURESI (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .hedef_kat     (hedef_kat),
        .istek_gecerli (istek_gecerli),
        .istek_hazir   (istek_hazir),
        .bulundugu_kat (bulundugu_kat),
        .yon_yukari    (yon_yukari),
        .yon_asagi     (yon_asagi),
        .kapi_acik     (kapi_acik),
        .mesgul        (mesgul)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request in BEKLE; returns after the acceptance edge (+1).
    task automatic request(input logic [1:0] h);
        hedef_kat     = h;
        istek_gecerli = 1'b1;
        tick();
        istek_gecerli = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        istek_gecerli = 1'b0;
        hedef_kat = 2'd0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bulundugu_kat !== 2'd0 || istek_hazir !== 1'b1 ||
            mesgul !== 1'b0 || kapi_acik !== 1'b0 ||
            yon_yukari !== 1'b0 || yon_asagi !== 1'b0) begin
            failures++;
            $display("FAIL reset: kat=%0d hazir=%b mesgul=%b kapi=%b up=%b dn=%b required kat=0 hazir=1 others 0",
                     bulundugu_kat, istek_hazir, mesgul, kapi_acik,
                     yon_yukari, yon_asagi);
        end
        tick();
        checks++;
        if (istek_hazir !== 1'b1 || bulundugu_kat !== 2'd0) begin
            failures++;
            $display("FAIL idle_hold: hazir=%b kat=%0d required 1/0",
                     istek_hazir, bulundugu_kat);
        end
    endtask

    task automatic test_same_floor();
        request(2'd0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (kapi_acik !== (k < 3) || istek_hazir !== (k == 3) ||
                mesgul !== (k < 3) || yon_yukari !== 1'b0 ||
                yon_asagi !== 1'b0 || bulundugu_kat !== 2'd0) begin
                failures++;
                $display("FAIL same_floor k=%0d: kapi=%b hazir=%b mesgul=%b up=%b dn=%b kat=%0d required kapi=%b hazir=%b",
                         k, kapi_acik, istek_hazir, mesgul, yon_yukari,
                         yon_asagi, bulundugu_kat, k < 3, k == 3);
            end
            if (k < 3) tick();
        end
    endtask

    task automatic test_up();
        int fl;
        request(2'd3);
        for (int k = 0; k <= 15; k++) begin
            fl = (k / 4 < 3) ? k / 4 : 3;
            checks++;
            if (bulundugu_kat !== 2'(fl) || yon_yukari !== (k < 12) ||
                yon_asagi !== 1'b0 ||
                kapi_acik !== (k >= 12 && k < 15) ||
                istek_hazir !== (k == 15)) begin
                failures++;
                $display("FAIL up k=%0d: kat=%0d up=%b dn=%b kapi=%b hazir=%b required kat=%0d up=%b kapi=%b hazir=%b",
                         k, bulundugu_kat, yon_yukari, yon_asagi, kapi_acik,
                         istek_hazir, fl, k < 12, k >= 12 && k < 15, k == 15);
            end
            if (k < 15) tick();
        end
    endtask

    task automatic test_down();
        int fl;
        request(2'd1);
        for (int k = 0; k <= 11; k++) begin
            fl = 3 - ((k / 4 < 2) ? k / 4 : 2);
            checks++;
            if (bulundugu_kat !== 2'(fl) || yon_asagi !== (k < 8) ||
                yon_yukari !== 1'b0 ||
                kapi_acik !== (k >= 8 && k < 11) ||
                istek_hazir !== (k == 11)) begin
                failures++;
                $display("FAIL down k=%0d: kat=%0d up=%b dn=%b kapi=%b hazir=%b required kat=%0d dn=%b kapi=%b hazir=%b",
                         k, bulundugu_kat, yon_yukari, yon_asagi, kapi_acik,
                         istek_hazir, fl, k < 8, k >= 8 && k < 11, k == 11);
            end
            if (k < 11) tick();
        end
    endtask

    task automatic test_busy();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        request(2'd2);
        for (int k = 0; k <= 11; k++) begin
            // Stray request pulses while the cab is travelling.
            istek_gecerli = (k == 2 || k == 5 || k == 9);
            hedef_kat     = 2'd3;
            checks++;
            if (istek_hazir !== (k == 11) ||
                bulundugu_kat !== 2'((k / 4 < 2) ? k / 4 : 2) ||
                kapi_acik !== (k >= 8 && k < 11)) begin
                failures++;
                $display("FAIL busy k=%0d: hazir=%b kat=%0d kapi=%b required hazir=%b",
                         k, istek_hazir, bulundugu_kat, kapi_acik, k == 11);
            end
            if (k < 11) tick();
        end
        istek_gecerli = 1'b0;
        tick();
        checks++;
        if (bulundugu_kat !== 2'd2 || istek_hazir !== 1'b1 ||
            yon_yukari !== 1'b0) begin
            failures++;
            $display("FAIL busy_final: kat=%0d hazir=%b up=%b required 2/1/0",
                     bulundugu_kat, istek_hazir, yon_yukari);
        end
    endtask

    task automatic test_reset_mid_move();
        request(2'd0);
        tick();
        checks++;
        if (yon_asagi !== 1'b1 || bulundugu_kat !== 2'd2) begin
            failures++;
            $display("FAIL mid_pre: dn=%b kat=%0d required 1/2",
                     yon_asagi, bulundugu_kat);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bulundugu_kat !== 2'd0 || istek_hazir !== 1'b1 ||
            yon_yukari !== 1'b0 || yon_asagi !== 1'b0 ||
            kapi_acik !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: kat=%0d hazir=%b up=%b dn=%b kapi=%b required 0/1/0/0/0",
                     bulundugu_kat, istek_hazir, yon_yukari, yon_asagi,
                     kapi_acik);
        end
        request(2'd1);
        checks++;
        if (yon_yukari !== 1'b1 || istek_hazir !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_req: up=%b hazir=%b required 1/0",
                     yon_yukari, istek_hazir);
        end
        for (int k = 1; k <= 4; k++) tick();
        checks++;
        if (bulundugu_kat !== 2'd1 || kapi_acik !== 1'b1 ||
            yon_yukari !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_arrive: kat=%0d kapi=%b up=%b required 1/1/0",
                     bulundugu_kat, kapi_acik, yon_yukari);
        end
    endtask

    // Invariants checked on every sample point.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if ((yon_yukari && yon_asagi) ||
                (kapi_acik && (yon_yukari || yon_asagi)) ||
                (mesgul === istek_hazir)) begin
                failures++;
                $display("FAIL invariant: up=%b dn=%b kapi=%b mesgul=%b hazir=%b",
                         yon_yukari, yon_asagi, kapi_acik, mesgul,
                         istek_hazir);
            end
        end
    end

    initial begin
        test_reset();
        test_same_floor();
        test_up();
        test_down();
        test_busy();
        test_reset_mid_move();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
